// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline stage register
package pipe_pkg;

    // Entry count doubles as the FSM state so occupancy can be driven straight from it.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    // Every control bit of the NOP encoding is zero; replicate to any CTRL_W.
    localparam logic NOP_CTRL_BIT = 1'b0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - handshake bundle between a producer, the stage and a consumer
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 18
) ();
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // The stage register itself.
    modport slave (
        input  flush, in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occupancy
    );

    // The surrounding pipeline (or a bench) driving and observing the stage.
    modport master (
        output flush, in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occupancy
    );
endinterface

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - load-enabled holding register with synchronous clear
module pipe_slot #(
    parameter int W = 50
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] slot_d;
    logic [W-1:0] slot_q;

    // Clear wins over load; otherwise hold the stored beat.
    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d = '0;
        end else if (load) begin
            slot_d = d;
        end
    end

    // Storage flop.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign q = slot_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised valid/ready pipeline stage register with optional skid entry
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 18,
    parameter int SKID   = 1
) (
    input logic            clk,
    input logic            reset,
    pipe_stage_reg_if.slave bus
);
    localparam int W = CTRL_W + DATA_W;

    occ_t         state_q;
    occ_t         state_d;
    logic         in_ready_q;
    logic         in_ready_d;
    logic         in_ready_int;
    logic         out_valid_int;
    logic         in_fire;
    logic         out_fire;
    logic         main_load;
    logic         skid_load;
    logic [W-1:0] in_beat;
    logic [W-1:0] main_in;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    assign in_beat       = {bus.in_ctrl, bus.in_data};
    assign out_valid_int = (state_q != EMPTY);
    // With a skid entry in_ready comes from a flop; without one it looks through to the consumer.
    assign in_ready_int  = (SKID != 0) ? in_ready_q
                                       : (!reset && (!out_valid_int || bus.out_ready));
    assign in_fire       = bus.in_valid && in_ready_int;
    assign out_fire      = out_valid_int && bus.out_ready;

    // State register: reset empties the stage and holds in_ready low.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Next state: occupancy follows the fires, flush forces empty regardless.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_fire) state_d = ONE;
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = TWO;
                end else if (!in_fire && out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO:     if (out_fire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (bus.flush) begin
            state_d = EMPTY;
        end
        in_ready_d = (state_d != TWO);
    end

    // Slot steering: main always holds the oldest beat, skid only catches the stall overflow.
    always_comb begin
        main_load = 1'b0;
        skid_load = 1'b0;
        main_in   = in_beat;
        if (!bus.flush) begin
            case (state_q)
                EMPTY: main_load = in_fire;
                ONE: begin
                    main_load = in_fire && out_fire;
                    skid_load = in_fire && !out_fire;
                end
                TWO: begin
                    main_load = out_fire;
                    main_in   = skid_q;
                end
                default: ;
            endcase
        end
    end

    pipe_slot #(.W(W)) u_main (
        .clk   (clk),
        .clear (reset),
        .load  (main_load),
        .d     (main_in),
        .q     (main_q)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(.W(W)) u_skid (
                .clk   (clk),
                .clear (reset),
                .load  (skid_load),
                .d     (in_beat),
                .q     (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign bus.out_ctrl  = out_valid_int ? main_q[W-1:DATA_W] : {CTRL_W{NOP_CTRL_BIT}};
    assign bus.out_data  = main_q[DATA_W-1:0];
    assign bus.occupancy = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, both SKID settings
module tb_pipe_stage_reg;
    localparam int DW = 32;
    localparam int CW = 18;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset_d = 1'b1;
    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) if_s1 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) if_s0 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut_s1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s1.slave)
    );
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut_s0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_s0.slave)
    );

    // Bench-side signals, routed to whichever DUT is active; the idle one is held flushed.
    logic          sel_skid = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    assign if_s1.flush     = sel_skid ? flush : 1'b1;
    assign if_s1.in_valid  = sel_skid ? in_valid : 1'b0;
    assign if_s1.in_ctrl   = in_ctrl;
    assign if_s1.in_data   = in_data;
    assign if_s1.out_ready = sel_skid ? out_ready : 1'b1;
    assign if_s0.flush     = !sel_skid ? flush : 1'b1;
    assign if_s0.in_valid  = !sel_skid ? in_valid : 1'b0;
    assign if_s0.in_ctrl   = in_ctrl;
    assign if_s0.in_data   = in_data;
    assign if_s0.out_ready = !sel_skid ? out_ready : 1'b1;
    assign in_ready  = sel_skid ? if_s1.in_ready  : if_s0.in_ready;
    assign out_valid = sel_skid ? if_s1.out_valid : if_s0.out_valid;
    assign out_ctrl  = sel_skid ? if_s1.out_ctrl  : if_s0.out_ctrl;
    assign out_data  = sel_skid ? if_s1.out_data  : if_s0.out_data;
    assign occupancy = sel_skid ? if_s1.occupancy : if_s0.occupancy;

    always @(posedge clk) reset_d <= reset;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Producer protocol: a stalled beat must be held stable until it is taken.
    assert property (@(posedge clk) disable iff (reset)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_ctrl) && $stable(in_data)))
    else begin
        failures++;
        $display("FAIL handshake_hold actual=dropped required=held");
    end

    // Reference model: FIFO of accepted, not yet delivered beats (at most one or two of them).
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;
    beat_t         exp_q[$];
    logic [DW-1:0] last_front = '0;
    int            max_occ = 0;
    bit            seen_a5 = 1'b0;
    int            cyc = 0;
    int            fire_cyc[$];

    // Monitor: samples mid-cycle, checks against the model, then applies this cycle's fires.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                exp_q.delete();
                last_front = '0;
            end else begin
                n = exp_q.size();
                chk("out_valid", out_valid, n > 0);
                chk("occupancy", occupancy, n);
                if (!reset_d)
                    chk("in_ready", in_ready, sel_skid ? (n < 2) : (n == 0 || out_ready));
                if (n > max_occ) max_occ = n;
                if (!out_valid) begin
                    chk("bubble_ctrl", out_ctrl, 0);
                    chk("hold_data", out_data, last_front);
                end else if (n > 0) begin
                    chk("beat_ctrl", out_ctrl, exp_q[0].c);
                    chk("beat_data", out_data, exp_q[0].d);
                    last_front = exp_q[0].d;
                    if (out_ready) begin
                        if (out_data == 32'hA5) seen_a5 = 1'b1;
                        void'(exp_q.pop_front());
                        fire_cyc.push_back(cyc);
                    end
                end
                if (flush) exp_q.delete();
                else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
            end
        end
    end

    // out_ready pattern generator: 0 always, 1 random, 2 alternating, 3 manual.
    int rmode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                2: out_ready = ~out_ready;
                default: ;
            endcase
        end
    end

    task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
        bit fired = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        for (int k = 0; k < 100 && !fired; k++) begin
            @(negedge clk);
            fired = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!fired) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=stalled required=accepted");
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset(input bit hold);
        reset    = 1'b1;
        flush    = 1'b0;
        in_valid = hold;
        in_ctrl  = 18'h5;
        in_data  = 32'h77;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_ctrl", out_ctrl, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_occupancy", occupancy, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", in_ready, 1);
        if (hold) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic stream_test(input string tag);
        fire_cyc.delete();
        rmode = 0;
        send(CW'($urandom), 32'd1);
        chk({tag, "_latency_valid"}, out_valid, 1);
        chk({tag, "_latency_data"}, out_data, 1);
        for (int i = 2; i <= 8; i++) send(CW'($urandom), DW'(i));
        drain();
        chk({tag, "_count"}, fire_cyc.size(), 8);
        if (fire_cyc.size() == 8) chk({tag, "_span"}, fire_cyc[7] - fire_cyc[0], 7);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // SKID=1 instance.
        sel_skid = 1'b1;
        do_reset(1'b1);
        drain();
        stream_test("s1_stream");

        // Backpressure mid-stream.
        rmode = 3;
        out_ready = 1'b1;
        max_occ = 0;
        fire_cyc.delete();
        fork
            begin
                for (int i = 1; i <= 8; i++) send(CW'($urandom), DW'(i + 16));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_max_occ", max_occ, 2);
        chk("bp_count", fire_cyc.size(), 8);

        // Flush with two held entries, then flush with a same-cycle accepted 0xA5.
        seen_a5 = 1'b0;
        out_ready = 1'b0;
        send(CW'($urandom), 32'h101);
        send(CW'($urandom), 32'h102);
        chk("pre_flush_occ", occupancy, 2);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush2_valid", out_valid, 0);
        chk("flush2_ctrl", out_ctrl, 0);
        chk("flush2_occ", occupancy, 0);
        send(CW'($urandom), 32'h103);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = CW'($urandom);
        in_data  = 32'hA5;
        @(negedge clk);
        chk("a5_taken", in_ready, 1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1_valid", out_valid, 0);
        chk("flush1_occ", occupancy, 0);
        rmode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("a5_absent", seen_a5, 0);

        // Bubble after an all-ones control beat.
        send(18'h3FFFF, 32'hCAFE0001);
        chk("bubble_head_ctrl", out_ctrl, 18'h3FFFF);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("bubble_valid", out_valid, 0);
            chk("bubble_zero_ctrl", out_ctrl, 0);
            chk("bubble_keep_data", out_data, 32'hCAFE0001);
        end

        // Random traffic with random backpressure and occasional flushes.
        rmode = 1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
            end
            send(CW'($urandom), $urandom);
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
        end
        rmode = 0;
        drain();

        // SKID=0 instance.
        sel_skid = 1'b0;
        do_reset(1'b0);
        stream_test("s0_stream");
        rmode = 2;
        max_occ = 0;
        for (int i = 0; i < 40; i++) send(CW'($urandom), $urandom);
        rmode = 0;
        drain();
        chk("s0_max_occ_le1", max_occ <= 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
